// File: rtl/mem_lsu_pkg.sv
// Shared widths, memory op codes and LSU state encodings for the MEM-stage load/store unit.
package mem_lsu_pkg;
  localparam int   RegBus     = 32;
  localparam int   RegAddrBus = 5;
  localparam int   MemOpBus   = 4;
  localparam logic RstEnable  = 1'b0;

  typedef enum logic [MemOpBus-1:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  function automatic logic is_store(mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_load(mem_op_e op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction
endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: byte enables, store replication, load extraction/extension.
// The misalign check exists only when MISALIGN_TRAP_EN is defined.
module mem_align
  import mem_lsu_pkg::*;
(
  input  mem_op_e           op_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [RegBus-1:0] sdata_i,
  input  logic [RegBus-1:0] rdata_i,
  output logic [3:0]        be_o,
  output logic [RegBus-1:0] wdata_o,
  output logic [RegBus-1:0] ldata_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);
  logic [1:0]        off;
  logic [RegBus-1:0] shifted;

  // Halfword/word offsets drop the low address bits they must not see.
  always_comb begin
    off     = 2'b00;
    be_o    = 4'b0000;
    wdata_o = sdata_i;
    case (op_i)
      MEM_SB, MEM_LB, MEM_LBU: begin
        off     = addr_lo_i;
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{sdata_i[7:0]}};
      end
      MEM_SH, MEM_LH, MEM_LHU: begin
        off     = {addr_lo_i[1], 1'b0};
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{sdata_i[15:0]}};
      end
      MEM_SW, MEM_LW: be_o = 4'b1111;
      default: ;
    endcase
  end

  assign shifted = rdata_i >> {off, 3'b000};

  always_comb begin
    ldata_o = shifted;
    case (op_i)
      MEM_LB:  ldata_o = {{24{shifted[7]}}, shifted[7:0]};
      MEM_LBU: ldata_o = {24'h0, shifted[7:0]};
      MEM_LH:  ldata_o = {{16{shifted[15]}}, shifted[15:0]};
      MEM_LHU: ldata_o = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign_o = (((op_i == MEM_LH) || (op_i == MEM_LHU) || (op_i == MEM_SH)) && addr_lo_i[0]) ||
                      (((op_i == MEM_LW) || (op_i == MEM_SW)) && (addr_lo_i != 2'b00));
`endif
endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid data-memory FSM with pipeline stall.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [RegAddrBus-1:0] reg_waddr_i,
  input  logic                  reg_we_i,
  input  logic [RegBus-1:0]     reg_wdata_i,
  input  logic [MemOpBus-1:0]   mem_op_i,
  input  logic [RegBus-1:0]     mem_sdata_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [RegBus-1:0]     dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [RegBus-1:0]     dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [RegBus-1:0]     dmem_rdata_i,
  output logic                  stall_o,
  output logic [RegAddrBus-1:0] reg_waddr_o,
  output logic                  reg_we_o,
  output logic [RegBus-1:0]     reg_wdata_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                  misalign_o
`endif
);
  lsu_state_e        state_q, state_d;
  mem_op_e           op;
  logic [RegBus-1:0] ldata;
  logic              misalign, req, stall, we, trap;

  assign op = mem_op_e'(mem_op_i);

  mem_align u_align (
    .op_i      (op),
    .addr_lo_i (reg_wdata_i[1:0]),
    .sdata_i   (mem_sdata_i),
    .rdata_i   (dmem_rdata_i),
    .be_o      (dmem_be_o),
    .wdata_o   (dmem_wdata_o),
    .ldata_o   (ldata)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_o(misalign)
`endif
  );

`ifndef MISALIGN_TRAP_EN
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RstEnable) state_q <= LSU_IDLE;
    else                    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    we      = 1'b0;
    trap    = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (op == MEM_NONE) begin
          we = reg_we_i;
        end else if (misalign) begin
          trap = 1'b1;
        end else begin
          req   = 1'b1;
          stall = !(dmem_gnt_i && is_store(op));
          if (!dmem_gnt_i)         state_d = LSU_REQ;
          else if (!is_store(op))  state_d = LSU_WAIT;
        end
      end
      LSU_REQ: begin
        req   = 1'b1;
        stall = !(dmem_gnt_i && is_store(op));
        if (dmem_gnt_i) state_d = is_store(op) ? LSU_IDLE : LSU_WAIT;
      end
      LSU_WAIT: begin
        stall = !dmem_rvalid_i;
        if (dmem_rvalid_i) begin
          we      = reg_we_i;
          state_d = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // Gating with reset drops the handshake outputs asynchronously mid-transaction.
  assign dmem_req_o  = rst_i & req;
  assign stall_o     = rst_i & stall;
  assign reg_we_o    = rst_i & we;
  assign dmem_we_o   = is_store(op);
  assign dmem_addr_o = {reg_wdata_i[RegBus-1:2], 2'b00};
  assign reg_waddr_o = reg_waddr_i;
  assign reg_wdata_o = is_load(op) ? ldata : reg_wdata_i;

`ifdef MISALIGN_TRAP_EN
  assign misalign_o = rst_i & trap;
`else
  logic unused_trap;
  assign unused_trap = trap ^ misalign;
`endif
endmodule

// File: tb/tb_mem_lsu.sv
// Directed, table-driven bench for mem_lsu; also covers MISALIGN_TRAP_EN builds.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_sdata_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int ntests = 0;
  int nfail  = 0;

  always #5 clk_i = ~clk_i;

  mem_lsu dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .mem_op_i(mem_op_i), .mem_sdata_i(mem_sdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o),
    .reg_wdata_o(reg_wdata_o)
`ifdef MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        gnt;
    logic        e_req, e_stall, e_we, e_dwe;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_daddr;
  } st_vec_t;

  typedef struct {
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] e_data;
  } ld_vec_t;

  st_vec_t sv[6];
  ld_vec_t lv[6];

  task automatic run_load(input string nm, input mem_op_e op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    int stalls;
    stalls = 0;
    mem_op_i = op; reg_wdata_i = addr; reg_we_i = 1'b1; reg_waddr_i = 5'd9;
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
    #1;
    chk({nm, "/req"}, 32'(dmem_req_o), 32'd1);
    chk({nm, "/addr"}, dmem_addr_o, {addr[31:2], 2'b00});
    chk({nm, "/we0"}, 32'(reg_we_o), 32'd0);
    if (stall_o) stalls++;
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
    #1;
    chk({nm, "/data"}, reg_wdata_o, exp);
    chk({nm, "/we1"}, 32'(reg_we_o), 32'd1);
    chk({nm, "/req1"}, 32'(dmem_req_o), 32'd0);
    if (stall_o) stalls++;
    chk({nm, "/stalls"}, 32'(stalls), 32'd1);
    tick();
    dmem_rvalid_i = 1'b0; mem_op_i = MEM_NONE;
    #1;
    chk({nm, "/idle"}, 32'(stall_o), 32'd0);
  endtask

  initial begin
    sv[0] = '{MEM_NONE, 32'h1234,     32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        32'h1234};
    sv[1] = '{MEM_SB,   32'h0001,     32'h0000_00AB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0};
    sv[2] = '{MEM_SB,   32'h0000_0003, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h7878_7878, 32'h0};
    sv[3] = '{MEM_SH,   32'h0000_0102, 32'h0000_CAFE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 32'hCAFE_CAFE, 32'h100};
    sv[4] = '{MEM_SH,   32'h0000_0100, 32'h5555_1357, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, 32'h1357_1357, 32'h100};
    sv[5] = '{MEM_SW,   32'h0000_0008, 32'h1122_3344, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h1122_3344, 32'h8};

    lv[0] = '{MEM_LB,  32'h1003, 32'h80FF_FFFF, 32'hFFFF_FF80};
    lv[1] = '{MEM_LBU, 32'h1003, 32'h80FF_FFFF, 32'h0000_0080};
    lv[2] = '{MEM_LH,  32'h0002, 32'h8001_1234, 32'hFFFF_8001};
    lv[3] = '{MEM_LHU, 32'h2002, 32'hBEEF_0000, 32'h0000_BEEF};
    lv[4] = '{MEM_LW,  32'h0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    lv[5] = '{MEM_LB,  32'h0000, 32'h0000_007F, 32'h0000_007F};

    // Reset state
    rst_i = 1'b0; reg_waddr_i = 5'd5; reg_we_i = 1'b1; reg_wdata_i = 32'h1234;
    mem_op_i = MEM_NONE; mem_sdata_i = 32'h0; dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    #3;
    chk("rst/req", 32'(dmem_req_o), 32'd0);
    chk("rst/stall", 32'(stall_o), 32'd0);
    chk("rst/we", 32'(reg_we_o), 32'd0);
    @(negedge clk_i); rst_i = 1'b1;
    tick();

    // Pass-through and stores granted immediately
    for (int i = 0; i < 6; i++) begin
      mem_op_i = sv[i].op; reg_wdata_i = sv[i].addr; mem_sdata_i = sv[i].sdata;
      dmem_gnt_i = sv[i].gnt; reg_we_i = 1'b1; reg_waddr_i = 5'(5 + i);
      #1;
      chk($sformatf("st%0d/req", i), 32'(dmem_req_o), 32'(sv[i].e_req));
      chk($sformatf("st%0d/stall", i), 32'(stall_o), 32'(sv[i].e_stall));
      chk($sformatf("st%0d/rwe", i), 32'(reg_we_o), 32'(sv[i].e_we));
      chk($sformatf("st%0d/waddr", i), 32'(reg_waddr_o), 32'(5 + i));
      chk($sformatf("st%0d/dwe", i), 32'(dmem_we_o), 32'(sv[i].e_dwe));
      chk($sformatf("st%0d/daddr", i), dmem_addr_o, sv[i].e_daddr);
      if (sv[i].op == MEM_NONE) begin
        chk($sformatf("st%0d/rdata", i), reg_wdata_o, sv[i].addr);
      end else begin
        chk($sformatf("st%0d/be", i), 32'(dmem_be_o), 32'(sv[i].e_be));
        chk($sformatf("st%0d/wdata", i), dmem_wdata_o, sv[i].e_wdata);
      end
      tick();
    end
    mem_op_i = MEM_NONE; dmem_gnt_i = 1'b0;

    // Loads: grant in cycle 0, rvalid in cycle 1
    for (int i = 0; i < 6; i++)
      run_load($sformatf("ld%0d", i), lv[i].op, lv[i].addr, lv[i].rdata, lv[i].e_data);

    // LHU with grant withheld three cycles, then one empty WAIT cycle
    mem_op_i = MEM_LHU; reg_wdata_i = 32'h2002; reg_we_i = 1'b1; dmem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_gnt_i = 1'b1;
      #1;
      chk($sformatf("lhu/req%0d", i), 32'(dmem_req_o), 32'd1);
      chk($sformatf("lhu/addr%0d", i), dmem_addr_o, 32'h2000);
      chk($sformatf("lhu/stall%0d", i), 32'(stall_o), 32'd1);
      tick();
    end
    dmem_gnt_i = 1'b0;
    #1;
    chk("lhu/wait_req", 32'(dmem_req_o), 32'd0);
    chk("lhu/wait_stall", 32'(stall_o), 32'd1);
    tick();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBEEF_0000;
    #1;
    chk("lhu/data", reg_wdata_o, 32'h0000_BEEF);
    chk("lhu/stall", 32'(stall_o), 32'd0);
    tick();
    dmem_rvalid_i = 1'b0; mem_op_i = MEM_NONE;

    // Store with delayed grant
    mem_op_i = MEM_SW; reg_wdata_i = 32'h40; mem_sdata_i = 32'hCAFE_F00D;
    #1;
    chk("swd/stall0", 32'(stall_o), 32'd1);
    tick();
    dmem_gnt_i = 1'b1;
    #1;
    chk("swd/req1", 32'(dmem_req_o), 32'd1);
    chk("swd/stall1", 32'(stall_o), 32'd0);
    chk("swd/we1", 32'(reg_we_o), 32'd0);
    tick();
    dmem_gnt_i = 1'b0; mem_op_i = MEM_NONE;
    #1;
    chk("swd/idle", 32'(stall_o), 32'd0);

    // Stray rvalid and grant in IDLE
    reg_we_i = 1'b1; reg_wdata_i = 32'h77; dmem_rvalid_i = 1'b1; dmem_gnt_i = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    #1;
    chk("stray/stall", 32'(stall_o), 32'd0);
    chk("stray/data", reg_wdata_o, 32'h77);
    tick();
    dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0;
    #1;
    chk("stray/stall2", 32'(stall_o), 32'd0);

    // Reset in REQ drops req at once
    mem_op_i = MEM_LW; reg_wdata_i = 32'h80;
    tick();
    #1;
    chk("rreq/req", 32'(dmem_req_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("rreq/req_rst", 32'(dmem_req_o), 32'd0);
    chk("rreq/stall_rst", 32'(stall_o), 32'd0);
    @(negedge clk_i); rst_i = 1'b1; mem_op_i = MEM_NONE;
    tick();

    // Reset in WAIT, then a late response
    mem_op_i = MEM_LW; reg_wdata_i = 32'h40; dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    #1;
    chk("rwait/stall", 32'(stall_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("rwait/stall_rst", 32'(stall_o), 32'd0);
    chk("rwait/req_rst", 32'(dmem_req_o), 32'd0);
    @(negedge clk_i); rst_i = 1'b1; mem_op_i = MEM_NONE; reg_we_i = 1'b0; reg_wdata_i = 32'h55;
    tick();
    chk("rwait/idle", 32'(stall_o), 32'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
    #1;
    chk("rwait/late_stall", 32'(stall_o), 32'd0);
    chk("rwait/late_data", reg_wdata_o, 32'h55);
    chk("rwait/late_we", 32'(reg_we_o), 32'd0);
    tick();
    dmem_rvalid_i = 1'b0;

    // LW at 0x6
    mem_op_i = MEM_LW; reg_wdata_i = 32'h6; reg_we_i = 1'b1; dmem_gnt_i = 1'b1;
    #1;
`ifdef MISALIGN_TRAP_EN
    chk("mis/flag", 32'(misalign_o), 32'd1);
    chk("mis/req", 32'(dmem_req_o), 32'd0);
    chk("mis/stall", 32'(stall_o), 32'd0);
    chk("mis/we", 32'(reg_we_o), 32'd0);
    tick();
    mem_op_i = MEM_NONE; dmem_gnt_i = 1'b0;
    #1;
    chk("mis/clear", 32'(misalign_o), 32'd0);
`else
    chk("mis/addr", dmem_addr_o, 32'h4);
    chk("mis/be", 32'(dmem_be_o), 32'hF);
    chk("mis/req", 32'(dmem_req_o), 32'd1);
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BAD_F00D;
    #1;
    chk("mis/data", reg_wdata_o, 32'h0BAD_F00D);
    tick();
    dmem_rvalid_i = 1'b0; mem_op_i = MEM_NONE;
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
